// File: rtl/multi_blink_pkg.sv
// multi_blink_pkg
// Shared types and constants for the multi-channel LED blinker.
//   blink_mode_t : per-channel mode encoding (matches CTRL[17:16])
//   ADDR_*       : fixed register addresses above the CTRL window
//   *_LSB/_MSB   : field positions inside CTRL and GLOBAL
package multi_blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PULSE = 2'd3
    } blink_mode_t;

    localparam logic [4:0] ADDR_GLOBAL = 5'd16;
    localparam logic [4:0] ADDR_STATUS = 5'd17;

    localparam int RATE_LSB = 0;
    localparam int RATE_MSB = 15;
    localparam int MODE_LSB = 16;
    localparam int MODE_MSB = 17;

    localparam int GLB_ENABLE_BIT = 0;
    localparam int GLB_SYNC_BIT   = 1;

endpackage

// File: rtl/blink_channel.sv
// blink_channel
// One LED channel: mode/rate register, millisecond counter, LED flop and
// pulse auto-clear.
//   clk, reset : clock and synchronous active-high reset
//   ms_tick    : one-cycle millisecond strobe from the shared prescaler
//   sync       : realign counters (BLINK restarts low, PULSE restarts high)
//   wr_en      : CTRL write for this channel, with wr_mode / wr_rate
//   led        : registered LED drive
//   mode, rate : current register contents for readback
//
// mode       | meaning
// MODE_OFF   | LED held 0
// MODE_ON    | LED held 1
// MODE_BLINK | LED toggles every rate ms; rate 0 holds LED and counter at 0
// MODE_PULSE | LED high for rate ms, then LED 0 and mode returns to OFF
module blink_channel
    import multi_blink_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ms_tick,
    input  logic        sync,
    input  logic        wr_en,
    input  blink_mode_t wr_mode,
    input  logic [15:0] wr_rate,
    output logic        led,
    output blink_mode_t mode,
    output logic [15:0] rate
);

    logic [15:0] ms_cnt;
    logic        at_end;

    // Only meaningful when rate != 0; rate 0 is handled on its own paths.
    assign at_end = (ms_cnt == (rate - 16'd1));

    // Priority: write > zero-length pulse clear > sync > tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode   <= MODE_OFF;
            rate   <= '0;
            ms_cnt <= '0;
            led    <= 1'b0;
        end else if (wr_en) begin
            mode   <= wr_mode;
            rate   <= wr_rate;
            ms_cnt <= '0;
            led    <= (wr_mode == MODE_ON) ||
                      ((wr_mode == MODE_PULSE) && (wr_rate != 16'd0));
        end else if ((mode == MODE_PULSE) && (rate == 16'd0)) begin
            // A zero-length pulse retires immediately, tick or not.
            mode   <= MODE_OFF;
            led    <= 1'b0;
            ms_cnt <= '0;
        end else if (sync) begin
            ms_cnt <= '0;
            if (mode == MODE_BLINK) begin
                led <= 1'b0;
            end else if (mode == MODE_PULSE) begin
                led <= 1'b1;
            end
        end else if (ms_tick) begin
            case (mode)
                MODE_BLINK: begin
                    if (rate == 16'd0) begin
                        led    <= 1'b0;
                        ms_cnt <= '0;
                    end else if (at_end) begin
                        ms_cnt <= '0;
                        led    <= ~led;
                    end else begin
                        ms_cnt <= ms_cnt + 16'd1;
                    end
                end
                MODE_PULSE: begin
                    if (at_end) begin
                        ms_cnt <= '0;
                        led    <= 1'b0;
                        mode   <= MODE_OFF;
                    end else begin
                        ms_cnt <= ms_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_blink_core.sv
// multi_blink_core
// N-channel LED blinker on the slot bus, with a shared millisecond prescaler.
//   clk, reset         : clock and synchronous active-high reset
//   cs, read, write    : slot strobes; a write happens on cs && write
//   addr, wr_data      : register address and write data
//   rd_data            : combinational readback of the register at addr
//   led_out            : registered LED outputs, one per channel
// Registers: 0..N-1 CTRL (mode[17:16], rate_ms[15:0]), 16 GLOBAL
// (bit0 enable, bit1 sync pulse), 17 STATUS (led_out).
module multi_blink_core
    import multi_blink_pkg::*;
#(
    parameter int N           = 8,
    parameter int CLK_FREQ_HZ = 100_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic [N-1:0] led_out
);

    localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic             bus_wr;
    logic             global_wr;
    logic             sync;
    logic             enable;
    logic             ms_tick;
    logic [PRE_W-1:0] pre_cnt;
    logic [N-1:0]     ctrl_wr;
    blink_mode_t      ch_mode [N];
    logic [15:0]      ch_rate [N];

    // Reads are side-effect free and CTRL/GLOBAL only use the low bits.
    logic unused_bus;
    assign unused_bus = ^{read, wr_data[31:18]};

    assign bus_wr    = cs && write;
    assign global_wr = bus_wr && (addr == ADDR_GLOBAL);
    assign sync      = global_wr && wr_data[GLB_SYNC_BIT];
    assign ms_tick   = enable && (pre_cnt == PRE_LAST);

    always_comb begin
        ctrl_wr = '0;
        for (int i = 0; i < N; i++) begin
            ctrl_wr[i] = bus_wr && (addr == 5'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable  <= 1'b1;
            pre_cnt <= '0;
        end else begin
            if (global_wr) begin
                enable <= wr_data[GLB_ENABLE_BIT];
            end
            if (sync) begin
                pre_cnt <= '0;
            end else if (enable) begin
                pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        blink_channel u_ch (
            .clk     (clk),
            .reset   (reset),
            .ms_tick (ms_tick),
            .sync    (sync),
            .wr_en   (ctrl_wr[i]),
            .wr_mode (blink_mode_t'(wr_data[MODE_MSB:MODE_LSB])),
            .wr_rate (wr_data[RATE_MSB:RATE_LSB]),
            .led     (led_out[i]),
            .mode    (ch_mode[i]),
            .rate    (ch_rate[i])
        );
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++) begin
            if (addr == 5'(i)) begin
                rd_data = {14'd0, ch_mode[i], ch_rate[i]};
            end
        end
        if (addr == ADDR_GLOBAL) begin
            rd_data = {31'd0, enable};
        end
        if (addr == ADDR_STATUS) begin
            rd_data = 32'(led_out);
        end
    end

endmodule

// File: doc/multi_blink_core.md
# multi_blink_core

- Parametrised N-channel LED blinker for an MMIO slot.
- Each channel has its own mode (off / on / blink / one-shot pulse) and a 16-bit millisecond rate.
- All channels share one millisecond prescaler, with global enable and phase-sync controls.
- Sits on the standard slot bus (cs/read/write/addr/wr_data/rd_data) and drives `led_out` to board LEDs.

## Interface
- `N`, 8: channel count, 1..16.
- `CLK_FREQ_HZ`, 100_000_000: clock frequency. `TICK_DIV = CLK_FREQ_HZ/1000` must be ≥ 1.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high; all state is cleared on the clk edge where it is high.
- `cs` in 1: slot select.
- `read` in 1: read strobe; reads have no side effects.
- `write` in 1: write strobe; a write occurs when `cs && write`.
- `addr` in 5: register address.
- `wr_data` in 32: write data.
- `rd_data` out 32: combinational readback of the register at `addr`.
- `led_out` out N: registered LED outputs.

## Operation
- Register map:
  - addr 0..N-1, CTRL[i]: bits[17:16] mode, bits[15:0] rate_ms. Other bits are ignored on write and read as 0.
  - addr 16, GLOBAL: bit0 enable, read/write. bit1 sync, write-1 pulse, reads 0.
  - addr 17, STATUS: read-only; bits[N-1:0] = `led_out`.
  - All other addresses: writes ignored, reads return 0.
- Modes:
  - 0 OFF: LED is 0.
  - 1 ON: LED is 1.
  - 2 BLINK: LED toggles every rate_ms ms, so the period is 2×rate_ms.
  - 3 PULSE: LED is 1 for rate_ms ms, then 0. Hardware then clears the mode field to 0 (OFF), visible on readback.
- Prescaler:
  - `pre_cnt` counts 0..TICK_DIV-1.
  - `ms_tick` is high for one cycle when `pre_cnt == TICK_DIV-1` and enable=1.
  - While enable=0, `pre_cnt` holds, there are no ticks, and every LED holds its state (frozen).
- Per-channel counter `ms_cnt` (16 bit), on each `ms_tick`:
  - BLINK: if `ms_cnt == rate-1`, then `ms_cnt←0` and LED toggles; otherwise `ms_cnt++`.
  - PULSE: if `ms_cnt == rate-1`, then LED←0, mode←0, `ms_cnt←0`; otherwise `ms_cnt++`.
- rate_ms = 0:
  - In BLINK, the LED is held at 0 and the counter is held at 0.
  - In PULSE, the LED stays 0 and the mode clears to 0 on the next cycle, without waiting for a tick.
- Write to CTRL[i]: `ms_cnt←0`. LED← 1 for ON or PULSE (with rate ≠ 0), otherwise 0. BLINK therefore always starts low.
- Sync (write GLOBAL with bit1=1):
  - `pre_cnt←0` and every `ms_cnt←0`.
  - BLINK LEDs ←0; PULSE channels restart their full high time.
  - OFF and ON channels are unaffected.
  - The enable bit is written from the same word.

## Timing
- Reset: all CTRL=0, enable=1, `pre_cnt=0`, `ms_cnt=0`, `led_out=0`, `rd_data` follows the regs (0).
- Write latency: a register and its LED update on the clk edge that samples the write, so the new value is visible the next cycle.
- `rd_data` is combinational, with zero latency after the register update.
- Simultaneous events:
  - A CTRL write and an `ms_tick` on the same cycle: the write wins, and that tick is not counted for that channel.
  - A sync write and an `ms_tick` on the same cycle: sync wins.
- A BLINK edge occurs exactly rate_ms×TICK_DIV cycles after the previous edge, measured from the write or sync cycle. A change in `ms_tick` alignment can make the first interval short by up to TICK_DIV-1 cycles; sync removes this misalignment.
- Reset in the middle of a pulse or blink aborts immediately; the LED is 0 the next cycle.
- `ms_cnt` never wraps past rate-1; the 16-bit rate maximum is 65535 ms.

## Structure
- Package `multi_blink_pkg`:
  - `typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_BLINK, MODE_PULSE} blink_mode_t`.
  - Address constants `ADDR_GLOBAL=5'd16` and `ADDR_STATUS=5'd17`.
  - Field bit positions.
- Sub-module `blink_channel`, instantiated N times via generate:
  - Inputs: clk, reset, ms_tick, sync, wr_en, wr_mode, wr_rate.
  - Outputs: led, mode, rate.
  - Contains the ms counter, LED flop, and pulse auto-clear.
- Top level holds the slot decode, prescaler, GLOBAL register and readback mux.

## Test plan
Use `CLK_FREQ_HZ=10_000` (`TICK_DIV=10`) and `N=4`.
1. Reset then idle:
   - `led_out=0`, GLOBAL reads 1, CTRL[0..3] read 0.
   - A read at addr 20 returns 0, and a write there changes nothing.
2. CTRL[1] = BLINK, rate 3 (0x0002_0003):
   - `led_out[1]` stays 0 for 30 cycles (±9 for the first interval), then toggles every 30 cycles.
   - After a sync write (0x3), the next rising edge is exactly 30 cycles after sync.
3. CTRL[2] = PULSE, rate 5 (0x0003_0005):
   - `led_out[2]` is 1 the next cycle.
   - It falls within 50±9 cycles, and CTRL[2] then reads 0x0000_0005.
4. CTRL[3] = ON, then GLOBAL=0 while CTRL[1] blinks:
   - `led_out[3]` stays 1 and `led_out[1]` freezes for 200 cycles.
   - GLOBAL=1 resumes toggling.
5. A CTRL[0] write on the same cycle as `ms_tick`:
   - The counter restarts and the first toggle is 10×rate cycles later.
   - BLINK with rate 0 keeps `led_out[0]=0`, and PULSE with rate 0 clears the mode in 1 cycle.
6. Reset asserted mid-blink and mid-pulse: the next cycle gives `led_out=0` and all CTRL=0; STATUS tracks `led_out` in every scenario.
